// File: rtl/adder_operand_sequencer_if.sv
// Bundle of the operand, adder and result handshake signals of the carry-select adder front end.
// The slave side is the sequencer; the master side is the operand source, adder and result sink.
interface adder_operand_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [15:0]      op_count;
  logic [15:0]      carry_count;
  logic             mismatch;

  modport slave (
    input  in_valid, in_a, in_b, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_cout,
           op_count, carry_count, mismatch
  );

  modport master (
    output in_valid, in_a, in_b, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_cout,
           op_count, carry_count, mismatch
  );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Operand FIFO and result capture stage around the external 16-bit carry-select adder,
// with capture statistics and a sticky reference check of every captured adder result.
module adder_operand_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  adder_operand_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  // True when the adder's {cout, sum} disagrees with the exact (WIDTH+1)-bit sum.
  function automatic logic result_differs(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] sum,
    input logic             cout
  );
    logic [WIDTH:0] ref_sum;
    ref_sum = {1'b0, a} + {1'b0, b};
    return (ref_sum != {cout, sum});
  endfunction

  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [2*WIDTH-1:0]   mem_r [DEPTH];
  logic [2*WIDTH-1:0]   head_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 capture_s;
  logic                 drop_s;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_sum_r;
  logic                 out_cout_r;
  logic [15:0]          op_count_r;
  logic [15:0]          carry_count_r;
  logic                 mismatch_r;

  // FIFO status, head selection and handshake decode, all from registered state.
  always_comb begin
    full_s    = 1'b0;
    empty_s   = 1'b0;
    head_s    = {(2*WIDTH){1'b0}};
    push_s    = 1'b0;
    capture_s = 1'b0;
    drop_s    = 1'b0;
    if (wr_ptr_r == rd_ptr_r) begin
      empty_s = 1'b1;
    end else if ((wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0])) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      head_s = {(2*WIDTH){1'b0}};
    end
    // No bypass: a full FIFO refuses input even when the head pops this cycle.
    push_s    = bus.in_valid && !full_s;
    capture_s = !empty_s && (!out_valid_r || bus.out_ready);
    drop_s    = out_valid_r && bus.out_ready && !capture_s;
  end

  // Operand storage; cleared on reset so a discarded pair can never reappear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(2*WIDTH){1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {bus.in_a, bus.in_b};
    end
  end

  // Read and write pointers; one extra bit separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (capture_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Result register: loads on capture, holds under backpressure, empties on hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= {WIDTH{1'b0}};
      out_cout_r  <= 1'b0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= bus.add_sum;
      out_cout_r  <= bus.add_cout;
    end else if (drop_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Capture statistics: wrapping transaction count and saturating carry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r    <= 16'h0000;
      carry_count_r <= 16'h0000;
    end else if (capture_s) begin
      op_count_r <= op_count_r + 16'h0001;
      if (bus.add_cout && (carry_count_r != 16'hFFFF)) begin
        carry_count_r <= carry_count_r + 16'h0001;
      end
    end
  end

  // Sticky reference check; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_r <= 1'b0;
    end else if (capture_s &&
                 result_differs(head_s[2*WIDTH-1:WIDTH], head_s[WIDTH-1:0],
                                bus.add_sum, bus.add_cout)) begin
      mismatch_r <= 1'b1;
    end
  end

  assign bus.in_ready    = !full_s;
  assign bus.add_a       = head_s[2*WIDTH-1:WIDTH];
  assign bus.add_b       = head_s[WIDTH-1:0];
  assign bus.out_valid   = out_valid_r;
  assign bus.out_sum     = out_sum_r;
  assign bus.out_cout    = out_cout_r;
  assign bus.op_count    = op_count_r;
  assign bus.carry_count = carry_count_r;
  assign bus.mismatch    = mismatch_r;

  adder_operand_sequencer_chk #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_ptr    (wr_ptr_r),
    .rd_ptr    (rd_ptr_r),
    .in_ready  (bus.in_ready),
    .out_valid (out_valid_r),
    .out_ready (bus.out_ready),
    .out_sum   (out_sum_r),
    .out_cout  (out_cout_r),
    .mismatch  (mismatch_r)
  );
endmodule

// Invariants of the sequencer: bounded occupancy, result hold under backpressure, sticky flag.
module adder_operand_sequencer_chk #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic [PW-1:0]    wr_ptr,
  input logic [PW-1:0]    rd_ptr,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] out_sum,
  input logic             out_cout,
  input logic             mismatch
);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] occ_s;
  assign occ_s = wr_ptr - rd_ptr;

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ_s <= DEPTH_P);

  a_full_blocks: assert property (@(posedge clk) disable iff (!rst_n)
    (occ_s == DEPTH_P) |-> !in_ready);

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_cout)));

  a_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    mismatch |=> mismatch);
endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench: vector table, backpressure/streaming/wrap/reset sequences,
// and random traffic scored against a queue-based model of the sequencer.
module tb_adder_operand_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [16:0] fault_add;

  always #5 clk = ~clk;

  adder_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

  adder_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Adder model; fault_add injects a wrong result for the self-check test.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + fault_add;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [7];

  logic [15:0] exp_ops;
  logic [15:0] exp_carry;

  // Reference model state for the random phase
  logic [31:0] mq [$];
  logic        m_ov;
  logic [15:0] m_sum;
  logic        m_cout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input logic iv, input logic ordy);
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] pair;
    logic [16:0] s;
    logic        cap;
    logic        psh;
    a = 16'($urandom);
    b = 16'($urandom);
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    check("rnd_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    check("rnd_head", {bus.add_a, bus.add_b}, (mq.size() > 0) ? mq[0] : 32'h0);
    cap = (mq.size() > 0) && (!m_ov || ordy);
    psh = iv && (mq.size() < DEPTH);
    if (cap) begin
      pair = mq.pop_front();
      s = {1'b0, pair[31:16]} + {1'b0, pair[15:0]};
      m_sum  = s[15:0];
      m_cout = s[16];
      m_ov   = 1'b1;
      exp_ops = exp_ops + 16'd1;
      if (m_cout && exp_carry != 16'hFFFF) exp_carry = exp_carry + 16'd1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (psh) mq.push_back({a, b});
    tick();
    check("rnd_out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      check("rnd_out_sum", 32'(bus.out_sum), 32'(m_sum));
      check("rnd_out_cout", 32'(bus.out_cout), 32'(m_cout));
    end
    check("rnd_op_count", 32'(bus.op_count), 32'(exp_ops));
    check("rnd_carry_count", 32'(bus.carry_count), 32'(exp_carry));
    check("rnd_mismatch", 32'(bus.mismatch), 32'h0);
  endtask

  initial begin
    int n;
    int t;
    vecs[0] = '{16'h0001, 16'h0001, 16'h0002, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[2] = '{16'hF1EF, 16'hF1EF, 16'hE3DE, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};

    fault_add     = 17'd0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0000;
    bus.in_b      = 16'h0000;
    bus.out_ready = 1'b1;

    // Asynchronous reset: outputs must change without a clock edge
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_sum", 32'(bus.out_sum), 32'h0);
    check("rst_out_cout", 32'(bus.out_cout), 32'h0);
    check("rst_op_count", 32'(bus.op_count), 32'h0);
    check("rst_carry_count", 32'(bus.carry_count), 32'h0);
    check("rst_mismatch", 32'(bus.mismatch), 32'h0);
    check("rst_head", {bus.add_a, bus.add_b}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table vectors: push at edge k, captured at edge k+1
    exp_ops   = 16'd0;
    exp_carry = 16'd0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = vecs[i].a;
      bus.in_b     = vecs[i].b;
      check("tbl_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid = 1'b0;
      check("tbl_head", {bus.add_a, bus.add_b}, {vecs[i].a, vecs[i].b});
      tick();
      exp_ops = exp_ops + 16'd1;
      if (vecs[i].cout) exp_carry = exp_carry + 16'd1;
      check("tbl_out_valid", 32'(bus.out_valid), 32'h1);
      check("tbl_out_sum", 32'(bus.out_sum), 32'(vecs[i].sum));
      check("tbl_out_cout", 32'(bus.out_cout), 32'(vecs[i].cout));
      check("tbl_op_count", 32'(bus.op_count), 32'(exp_ops));
      check("tbl_mismatch", 32'(bus.mismatch), 32'h0);
    end
    check("tbl_carry_count", 32'(bus.carry_count), 32'h4);

    // Backpressure: five pairs fill the result register plus the FIFO
    tick();
    check("bp_idle", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'(16'h10 * (i + 1));
      bus.in_b     = 16'(16'h10 * (i + 1));
      check("bp_in_ready_open", 32'(bus.in_ready), 32'h1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_in_ready_full", 32'(bus.in_ready), 32'h0);
    check("bp_held_sum", 32'(bus.out_sum), 32'h20);
    tick();
    tick();
    check("bp_hold_sum", 32'(bus.out_sum), 32'h20);
    check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
    check("bp_hold_full", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check("bp_drain_valid", 32'(bus.out_valid), 32'h1);
      check("bp_drain_sum", 32'(bus.out_sum), 32'(16'h20 * (i + 1)));
      check("bp_drain_in_ready", 32'(bus.in_ready), 32'h1);
    end
    tick();
    check("bp_drain_done", 32'(bus.out_valid), 32'h0);
    exp_ops = exp_ops + 16'd5;
    check("bp_op_count", 32'(bus.op_count), 32'(exp_ops));

    // Streaming: 48 back-to-back pairs, one result per cycle
    for (int j = 1; j <= 49; j++) begin
      bus.in_valid = (j <= 48);
      bus.in_a     = 16'(j);
      bus.in_b     = 16'(j);
      tick();
      if (j >= 2) begin
        check("str_valid", 32'(bus.out_valid), 32'h1);
        check("str_sum", 32'(bus.out_sum), 32'(2 * (j - 1)));
      end
    end
    bus.in_valid = 1'b0;
    exp_ops = exp_ops + 16'd48;
    check("str_op_count", 32'(bus.op_count), 32'(exp_ops));
    tick();
    check("str_done", 32'(bus.out_valid), 32'h0);

    // Random traffic against the queue model
    m_ov = 1'b0;
    mq.delete();
    for (int c = 0; c < 300; c++) begin
      rand_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < DEPTH + 2; c++) begin
      rand_cycle(1'b0, 1'b1);
    end

    // Long carry stream: op_count wraps past 0xFFFF, carry_count saturates
    n = 65540;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'hFFFF;
    bus.in_b      = 16'hFFFF;
    bus.out_ready = 1'b1;
    repeat (n) tick();
    bus.in_valid = 1'b0;
    tick();
    check("sat_sum", 32'(bus.out_sum), 32'hFFFE);
    check("sat_cout", 32'(bus.out_cout), 32'h1);
    tick();
    exp_ops = 16'(exp_ops + 16'(n));
    t = int'(exp_carry) + n;
    exp_carry = (t > 65535) ? 16'hFFFF : 16'(t);
    check("sat_op_count", 32'(bus.op_count), 32'(exp_ops));
    check("sat_carry_count", 32'(bus.carry_count), 32'(exp_carry));
    check("sat_mismatch", 32'(bus.mismatch), 32'h0);

    // Self-check: faulty adder sets mismatch, which stays set
    fault_add    = 17'd1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0003;
    bus.in_b     = 16'h0003;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("sc_bad_sum", 32'(bus.out_sum), 32'h7);
    check("sc_mismatch_set", 32'(bus.mismatch), 32'h1);
    fault_add    = 17'd0;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0001;
    bus.in_b     = 16'h0002;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("sc_good_sum", 32'(bus.out_sum), 32'h3);
    check("sc_mismatch_sticky", 32'(bus.mismatch), 32'h1);
    tick();

    // Reset mid-stream: three pairs buffered and one result held
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'(16'h11 * i);
      bus.in_b     = 16'h0000;
      tick();
    end
    bus.in_valid = 1'b0;
    check("mr_pre_valid", 32'(bus.out_valid), 32'h1);
    check("mr_pre_head", 32'(bus.add_a), 32'h22);
    #2 rst_n = 1'b0;
    #1;
    check("mr_in_ready", 32'(bus.in_ready), 32'h1);
    check("mr_out_valid", 32'(bus.out_valid), 32'h0);
    check("mr_out_sum", 32'(bus.out_sum), 32'h0);
    check("mr_op_count", 32'(bus.op_count), 32'h0);
    check("mr_carry_count", 32'(bus.carry_count), 32'h0);
    check("mr_mismatch", 32'(bus.mismatch), 32'h0);
    check("mr_head", {bus.add_a, bus.add_b}, 32'h0);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h0100;
    bus.in_b      = 16'h0200;
    check("mr_post_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mr_post_valid", 32'(bus.out_valid), 32'h1);
    check("mr_post_sum", 32'(bus.out_sum), 32'h0300);
    check("mr_post_op_count", 32'(bus.op_count), 32'h1);
    tick();
    check("mr_post_empty", 32'(bus.out_valid), 32'h0);
    check("mr_post_head", {bus.add_a, bus.add_b}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
